// File: rtl/nand_share_arbiter.sv
// Round-robin sequencer time-sharing one _nand evaluator among NUM_REQ requesters.
// Optional NAND_ARB_SUPPLY_GATE_EN: gate the cell supply outside WAKE/SETTLE.
module nand_share_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int INPUT_WIDTH   = 4,
    parameter int SETTLE_CYCLES = 2,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic                           clock,
    input  logic                           nReset,
    input  logic [NUM_REQ-1:0]             reqValid,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]             reqAck,
    output logic                           respData,
    output logic                           busy,
    output logic [GW-1:0]                  grantIdx,
    output logic [INPUT_WIDTH-1:0]         nandInput,
    output logic [1:0]                     nandSupply,
    input  logic                           nandOutput
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAKE    = 2'd1,
        SETTLE  = 2'd2,
        RESPOND = 2'd3
    } state_t;

    localparam logic [1:0] SUP_ON  = 2'b10;
    localparam logic [1:0] SUP_OFF = 2'b00;

    state_t                   state_q;
    logic [CW-1:0]            cnt_q;
    logic [GW-1:0]            last_q;
    logic [GW-1:0]            grant_q;
    logic [NUM_REQ-1:0]       ack_q;
    logic                     resp_q;
    logic                     busy_q;
    logic [INPUT_WIDTH-1:0]   opnd_q;

    logic                     pick_found_d;
    logic [GW-1:0]            pick_idx_d;

    // First pending request searching upward from the slot after lastGrant.
    always_comb begin
        int j;
        j            = 0;
        pick_found_d = 1'b0;
        pick_idx_d   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(last_q) + 1 + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!pick_found_d && reqValid[j]) begin
                pick_found_d = 1'b1;
                pick_idx_d   = GW'(j);
            end
        end
    end

`ifdef NAND_ARB_SUPPLY_GATE_EN
    logic [1:0] sup_q;
`endif

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            grant_q <= '0;
            ack_q   <= '0;
            resp_q  <= 1'b0;
            busy_q  <= 1'b0;
            opnd_q  <= '0;
`ifdef NAND_ARB_SUPPLY_GATE_EN
            sup_q   <= SUP_OFF;
`endif
        end else begin
            ack_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (pick_found_d) begin
                        grant_q <= pick_idx_d;
                        opnd_q  <= reqData[pick_idx_d*INPUT_WIDTH +: INPUT_WIDTH];
                        cnt_q   <= CW'(SETTLE_CYCLES - 1);
                        busy_q  <= 1'b1;
`ifdef NAND_ARB_SUPPLY_GATE_EN
                        sup_q   <= SUP_ON;
                        state_q <= WAKE;
`else
                        state_q <= SETTLE;
`endif
                    end
                end
                WAKE: begin
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        resp_q         <= nandOutput;
                        ack_q[grant_q] <= 1'b1;
                        state_q        <= RESPOND;
`ifdef NAND_ARB_SUPPLY_GATE_EN
                        sup_q          <= SUP_OFF;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESPOND: begin
                    last_q  <= grant_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign reqAck    = ack_q;
    assign respData  = resp_q;
    assign busy      = busy_q;
    assign grantIdx  = grant_q;
    assign nandInput = opnd_q;

`ifdef NAND_ARB_SUPPLY_GATE_EN
    assign nandSupply = sup_q;
`else
    assign nandSupply = SUP_ON;
`endif

endmodule

// File: tb/tb_nand_share_arbiter.sv
// Directed bench for nand_share_arbiter with a behavioural NAND fed back.
// Build with +define+NAND_ARB_SUPPLY_GATE_EN to exercise supply gating.
module tb_nand_share_arbiter;

    localparam int N = 4;
    localparam int W = 4;
    localparam int S = 2;
`ifdef NAND_ARB_SUPPLY_GATE_EN
    localparam int GATE = 1;
`else
    localparam int GATE = 0;
`endif
    localparam int LAT = S + 1 + GATE;
    localparam int PER = S + 2 + GATE;
    localparam logic [1:0] SUP_IDLE = GATE ? 2'b00 : 2'b10;

    logic           clock;
    logic           nReset;
    logic [N-1:0]   reqValid;
    logic [N*W-1:0] reqData;
    logic [N-1:0]   reqAck;
    logic           respData;
    logic           busy;
    logic [1:0]     grantIdx;
    logic [W-1:0]   nandInput;
    logic [1:0]     nandSupply;
    logic           nandOutput;

    int tests;
    int fails;

    nand_share_arbiter #(
        .NUM_REQ      (N),
        .INPUT_WIDTH  (W),
        .SETTLE_CYCLES(S)
    ) dut (
        .clock     (clock),
        .nReset    (nReset),
        .reqValid  (reqValid),
        .reqData   (reqData),
        .reqAck    (reqAck),
        .respData  (respData),
        .busy      (busy),
        .grantIdx  (grantIdx),
        .nandInput (nandInput),
        .nandSupply(nandSupply),
        .nandOutput(nandOutput)
    );

    assign nandOutput = ~&nandInput;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic service(input string tag,
                           input logic [3:0] exp_ack,
                           input logic [1:0] exp_idx,
                           input logic exp_resp,
                           input int exp_n,
                           input bit chk_sup);
        int  n;
        bit  seen;
        logic [1:0] es;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clock);
            #1;
            n++;
            if (chk_sup) begin
                es = (GATE != 0 && n == exp_n) ? 2'b00 : 2'b10;
                check({tag, "_sup"}, 32'(nandSupply), 32'(es));
            end
            if (reqAck != '0) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_ack"}, 32'(reqAck), 32'(exp_ack));
        check({tag, "_lat"}, n, exp_n);
        check({tag, "_resp"}, 32'(respData), 32'(exp_resp));
        check({tag, "_gidx"}, 32'(grantIdx), 32'(exp_idx));
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic do_reset();
        nReset   = 1'b0;
        reqValid = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        nReset = 1'b1;
    endtask

    logic [3:0] sat_ack [4];
    logic       sat_res [4];

    initial begin
        tests    = 0;
        fails    = 0;
        nReset   = 1'b0;
        reqValid = '0;
        reqData  = '0;
        sat_ack  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        sat_res  = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(reqAck), 32'd0);
        check("rst_resp", 32'(respData), 32'd0);
        check("rst_opnd", 32'(nandInput), 32'd0);
        check("rst_gidx", 32'(grantIdx), 32'd0);
        check("rst_sup", 32'(nandSupply), 32'(SUP_IDLE));

        @(negedge clock);
        reqData  = 16'h0F00;
        reqValid = 4'b0100;
        service("single_f", 4'b0100, 2'd2, 1'b0, LAT, 1'b1);
        check("single_f_opnd", 32'(nandInput), 32'hF);
        @(negedge clock);
        reqValid = '0;
        @(posedge clock);
        #1;
        check("single_f_pulse", 32'(reqAck), 32'd0);
        check("single_f_idle", 32'(busy), 32'd0);
        check("single_f_supidle", 32'(nandSupply), 32'(SUP_IDLE));

        @(negedge clock);
        reqData  = 16'h0500;
        reqValid = 4'b0100;
        service("single_5", 4'b0100, 2'd2, 1'b1, LAT, 1'b1);
        check("single_5_opnd", 32'(nandInput), 32'h5);
        @(negedge clock);
        reqValid = '0;

        do_reset();
        reqData  = 16'h0F5F;
        reqValid = 4'b1111;
        service("sat0", 4'b0001, 2'd0, 1'b0, LAT, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            service($sformatf("sat%0d", i), sat_ack[i % 4],
                    2'(i % 4), sat_res[i % 4], PER, 1'b0);
        end
        @(negedge clock);
        reqValid = '0;

        do_reset();
        reqData  = 16'h0F50;
        reqValid = 4'b0110;
        service("rr_a", 4'b0010, 2'd1, 1'b1, LAT, 1'b1);
        service("rr_b", 4'b0100, 2'd2, 1'b0, PER, 1'b0);
        @(negedge clock);
        reqValid = 4'b0010;
        service("rr_c", 4'b0010, 2'd1, 1'b1, PER, 1'b0);
        @(negedge clock);
        reqValid = '0;
        @(posedge clock);

        @(negedge clock);
        reqData  = 16'h0000;
        reqValid = 4'b1000;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_gidx", 32'(grantIdx), 32'd3);
        #2;
        nReset = 1'b0;
        #1;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_ack", 32'(reqAck), 32'd0);
        check("mr_opnd", 32'(nandInput), 32'd0);
        check("mr_gidx", 32'(grantIdx), 32'd0);
        check("mr_resp", 32'(respData), 32'd0);
        check("mr_sup", 32'(nandSupply), 32'(SUP_IDLE));
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("mr_noack%0d", i), 32'(reqAck), 32'd0);
        end
        @(negedge clock);
        nReset   = 1'b1;
        reqData  = 16'h0005;
        reqValid = 4'b1001;
        service("post_rst", 4'b0001, 2'd0, 1'b1, LAT, 1'b1);
        @(negedge clock);
        reqValid = '0;
        repeat (2) @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
